// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Bursts are bounded per grant, and a high/low watermark throttle pauses writes.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int HIGH_WM   = 5,
  parameter int LOW_WM    = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           fifo_data,
  input  logic [CNT_W-1:0]            fifo_words,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        stopped
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  localparam logic [GW-1:0]    LAST_IDX   = GW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] HIGH_LV    = CNT_W'(HIGH_WM);
  localparam logic [CNT_W-1:0] LOW_LV     = CNT_W'(LOW_WM);
  localparam logic [BW-1:0]    BURST_LAST = BW'(BURST_MAX - 1);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WRITING       = 3'd1,
    WAIT_TO_STOP  = 3'd2,
    STOPPED       = 3'd3,
    WAIT_TO_START = 3'd4
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [GW-1:0]   last_grant;
  logic [BW-1:0]   burst_cnt;
  logic [GW-1:0]   arb_pick;
  logic            above_high;
  logic            burst_done;

  // Handshake: req[i] acts as valid and must hold with its data until ack[i];
  // ack[i] is high in exactly the cycle the word is written, sampled at the edge.
  assign above_high = (fifo_words >= HIGH_LV);

  // Search starts one past the previous grantee and wraps; first set bit wins.
  always_comb begin
    logic [GW-1:0] cand;
    logic          found;
    cand     = last_grant;
    found    = 1'b0;
    arb_pick = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        arb_pick = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    wr_en      = 1'b0;
    ack        = '0;
    burst_done = 1'b0;
    stopped    = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (above_high)  next_state = WAIT_TO_STOP;
        else if (|req)   next_state = WRITING;
      end
      WRITING: begin
        wr_en         = req[grant_id] && !above_high;
        ack[grant_id] = wr_en;
        burst_done    = wr_en && (burst_cnt == BURST_LAST);
        if (above_high)           next_state = WAIT_TO_STOP;
        else if (burst_done)      next_state = IDLE;
        else if (!req[grant_id])  next_state = IDLE;
      end
      WAIT_TO_STOP: begin
        stopped    = 1'b1;
        next_state = STOPPED;
      end
      STOPPED: begin
        stopped = 1'b1;
        if (fifo_words <= LOW_LV) next_state = WAIT_TO_START;
      end
      WAIT_TO_START: begin
        stopped    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign fifo_data = req_data[grant_id*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= LAST_IDX;
      burst_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == WRITING) begin
        grant_id  <= arb_pick;
        burst_cnt <= '0;
      end
      if (state == WRITING) begin
        if (wr_en) burst_cnt <= burst_cnt + 1'b1;
        // Any exit, including a throttle, forfeits the grant.
        if (next_state != WRITING) last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: hysteresis, round robin, early release,
// idle throttle, asynchronous reset mid-burst and sparse requests.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        wr_en;
  logic [7:0]  fifo_data;
  logic [3:0]  fifo_words;
  logic [1:0]  grant_id;
  logic        stopped;

  int checks;
  int errors;

  fifo_write_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .CNT_W(4), .HIGH_WM(5), .LOW_WM(2), .BURST_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .wr_en(wr_en),
    .fifo_data(fifo_data),
    .fifo_words(fifo_words),
    .grant_id(grant_id),
    .stopped(stopped)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req        = '0;
    fifo_words = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req        = '0;
    req_data   = '0;
    fifo_words = '0;
    #3;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", wr_en); end
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", ack); end
    checks++;
    if (stopped !== 1'b0) begin errors++; $display("FAIL reset_stopped got %0b exp 0", stopped); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
  endtask

  task automatic test_hysteresis();
    logic [3:0] fw_t [14] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4,
                              4'd5, 4'd5, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2};
    logic       wr_t [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       st_t [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    req_data = 32'h0000_00AA;
    req      = 4'b0001;
    for (int c = 0; c < 14; c++) begin
      fifo_words = fw_t[c];
      #1;
      checks++;
      if (wr_en !== wr_t[c]) begin
        errors++; $display("FAIL hyst_wr_en c=%0d got %0b exp %0b", c, wr_en, wr_t[c]);
      end
      checks++;
      if (ack !== (wr_t[c] ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL hyst_ack c=%0d got %b exp %0b", c, ack, wr_t[c]);
      end
      checks++;
      if (stopped !== st_t[c]) begin
        errors++; $display("FAIL hyst_stopped c=%0d got %0b exp %0b", c, stopped, st_t[c]);
      end
      if (wr_t[c]) begin
        checks++;
        if (fifo_data !== 8'hAA) begin
          errors++; $display("FAIL hyst_data c=%0d got %h exp aa", c, fifo_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] d_exp [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    logic [3:0] a_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    req_data   = 32'h4332_2110;
    req        = 4'b1111;
    fifo_words = '0;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (wr_en !== 1'b0) begin
        errors++; $display("FAIL rr_bubble n=%0d got wr_en %0b exp 0", n, wr_en);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (grant_id !== g_seq[n]) begin
          errors++; $display("FAIL rr_grant n=%0d b=%0d got %0d exp %0d", n, b, grant_id, g_seq[n]);
        end
        checks++;
        if (wr_en !== 1'b1 || ack !== a_exp[g_seq[n]]) begin
          errors++; $display("FAIL rr_ack n=%0d b=%0d got wr %0b ack %b exp 1 %b",
                             n, b, wr_en, ack, a_exp[g_seq[n]]);
        end
        checks++;
        if (fifo_data !== d_exp[g_seq[n]]) begin
          errors++; $display("FAIL rr_data n=%0d b=%0d got %h exp %h", n, b, fifo_data, d_exp[g_seq[n]]);
        end
        tick();
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    req_data   = 32'h4332_2110;
    req        = 4'b1110;
    fifo_words = '0;
    tick();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (ack !== 4'b0010 || grant_id !== 2'd1) begin
        errors++; $display("FAIL early_ack b=%0d got ack %b grant %0d exp 0010 1", b, ack, grant_id);
      end
      tick();
    end
    req = 4'b1100;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL early_drop got wr_en %0b exp 0", wr_en); end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL early_bubble got wr_en %0b exp 0", wr_en); end
    tick();
    checks++;
    if (grant_id !== 2'd2 || ack !== 4'b0100) begin
      errors++; $display("FAIL early_next got grant %0d ack %b exp 2 0100", grant_id, ack);
    end
    checks++;
    if (fifo_data !== 8'h32) begin errors++; $display("FAIL early_data got %h exp 32", fifo_data); end
  endtask

  task automatic test_throttle_idle();
    logic [3:0] fw_t [7] = '{4'd7, 4'd7, 4'd7, 4'd2, 4'd2, 4'd2, 4'd2};
    logic       st_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       wr_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    req_data = 32'h4332_2110;
    req      = 4'b1000;
    for (int c = 0; c < 7; c++) begin
      fifo_words = fw_t[c];
      #1;
      checks++;
      if (stopped !== st_t[c]) begin
        errors++; $display("FAIL thr_stopped c=%0d got %0b exp %0b", c, stopped, st_t[c]);
      end
      checks++;
      if (ack !== (wr_t[c] ? 4'b1000 : 4'b0000) || wr_en !== wr_t[c]) begin
        errors++; $display("FAIL thr_ack c=%0d got ack %b wr %0b exp wr %0b", c, ack, wr_en, wr_t[c]);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_data   = 32'h4332_2110;
    req        = 4'b0001;
    fifo_words = '0;
    repeat (3) tick();
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL arst_pre got wr_en %0b exp 1", wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || ack !== 4'b0000) begin
      errors++; $display("FAIL arst_drop got wr %0b ack %b exp 0 0000", wr_en, ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    checks++;
    if (grant_id !== 2'd0 || ack !== 4'b0001) begin
      errors++; $display("FAIL arst_first got grant %0d ack %b exp 0 0001", grant_id, ack);
    end
  endtask

  task automatic test_sparse();
    apply_reset();
    req_data   = 32'h4332_2110;
    req        = 4'b0100;
    fifo_words = '0;
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (grant_id !== 2'd2 || ack !== 4'b0100) begin
        errors++; $display("FAIL sparse_burst b=%0d got grant %0d ack %b exp 2 0100", b, grant_id, ack);
      end
      tick();
    end
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL sparse_bubble got wr_en %0b exp 0", wr_en); end
    tick();
    checks++;
    if (grant_id !== 2'd2 || ack !== 4'b0100) begin
      errors++; $display("FAIL sparse_regrant got grant %0d ack %b exp 2 0100", grant_id, ack);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hysteresis();
    test_round_robin();
    test_early_release();
    test_throttle_idle();
    test_async_reset();
    test_sparse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
